// File: rtl/tx_serial_8n1_if.sv
// Purpose : handshake bundle between a byte source and the 8N1 serial transmitter.
// Latency : none, plain wires.
// Backpressure: the source must only raise partida while ocupado is low; otherwise the request is ignored.
//
// Signals:
//   partida      source -> tx : start request, sampled on the rising clock edge
//   dados_ascii  source -> tx : byte to send, captured when partida is accepted
//   ocupado      tx -> source : high while a frame is on the line
//   pronto       tx -> source : one-cycle pulse when a frame completes
interface tx_serial_8n1_if;
    logic       partida;
    logic [7:0] dados_ascii;
    logic       ocupado;
    logic       pronto;

    modport master (
        output partida,
        output dados_ascii,
        input  ocupado,
        input  pronto
    );

    modport slave (
        input  partida,
        input  dados_ascii,
        output ocupado,
        output pronto
    );
endinterface

// File: rtl/tx_serial_8n1.sv
// Purpose : UART transmitter, start bit + 8 data bits LSB first (+ optional odd parity) + stop bit(s).
// Latency : start bit on the line from the accepting edge; pronto one cycle after the last stop bit ends.
// Backpressure: requests are ignored while a frame (including its one-cycle FINAL state) is in progress.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous, active-high
//   bus (slave)      partida / dados_ascii in, ocupado / pronto out
//   saida_serial     serial line, idles high, driven directly from a flop
//   db_tick          high in each cycle where the bit counter sits at CLOCKS_PER_BIT-1
//   db_estado        current FSM state code (INICIAL=0, TRANSMISSAO=1, FINAL=2)
//   db_saida_serial  copy of saida_serial
//
// Optional feature: define TX_SERIAL_PARITY_EN to insert an odd-parity bit between
// data bit 7 and the stop bits (8O1 / 8O2 framing).
module tx_serial_8n1 #(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int STOP_BITS      = 1
) (
    input  logic             clock,
    input  logic             reset,
    tx_serial_8n1_if.slave   bus,
    output logic             saida_serial,
    output logic             db_tick,
    output logic [3:0]       db_estado,
    output logic             db_saida_serial
);

    localparam logic [1:0] INICIAL     = 2'd0;
    localparam logic [1:0] TRANSMISSAO = 2'd1;
    localparam logic [1:0] FINAL       = 2'd2;

`ifdef TX_SERIAL_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Bits per frame: start + 8 data + parity + stop bits.
    localparam int FRAME_BITS = 9 + PARITY_BITS + STOP_BITS;
    localparam int CW         = $clog2(CLOCKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [3:0]    IDX_LAST = 4'(FRAME_BITS - 1);

    logic [1:0]            estado;
    logic [CW-1:0]         cnt;
    logic [3:0]            idx;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] frame_word;
    logic                  bit_wrap;

    // Complete frame as it leaves the line, LSB first. Built from the live
    // inputs but only sampled on the accepting edge, so later changes on
    // dados_ascii never reach a frame already in flight.
`ifdef TX_SERIAL_PARITY_EN
    // Odd parity: data ones plus this bit is always odd.
    assign frame_word = {{STOP_BITS{1'b1}}, ~^bus.dados_ascii, bus.dados_ascii, 1'b0};
`else
    assign frame_word = {{STOP_BITS{1'b1}}, bus.dados_ascii, 1'b0};
`endif

    assign bit_wrap = (estado == TRANSMISSAO) && (cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= INICIAL;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            saida_serial <= 1'b1;
        end else begin
            case (estado)
                INICIAL: begin
                    saida_serial <= 1'b1;
                    if (bus.partida) begin
                        shreg        <= frame_word;
                        cnt          <= '0;
                        idx          <= '0;
                        estado       <= TRANSMISSAO;
                        // Start bit appears on the same edge the request is taken.
                        saida_serial <= frame_word[0];
                    end
                end

                TRANSMISSAO: begin
                    if (bit_wrap) begin
                        cnt   <= '0;
                        idx   <= idx + 4'd1;
                        // Ones shifted in keep the line high should the
                        // register ever be read past the last stop bit.
                        shreg <= {1'b1, shreg[FRAME_BITS-1:1]};
                        if (idx == IDX_LAST) begin
                            estado       <= FINAL;
                            saida_serial <= 1'b1;
                        end else begin
                            // Drive the next bit now so the line stays a pure flop output.
                            saida_serial <= shreg[1];
                        end
                    end else begin
                        cnt          <= cnt + CW'(1);
                        saida_serial <= shreg[0];
                    end
                end

                FINAL: begin
                    // Single completion cycle; partida is not looked at here,
                    // so a held request restarts from INICIAL on the next edge.
                    saida_serial <= 1'b1;
                    estado       <= INICIAL;
                end

                default: begin
                    saida_serial <= 1'b1;
                    estado       <= INICIAL;
                end
            endcase
        end
    end

    assign bus.ocupado     = (estado == TRANSMISSAO);
    assign bus.pronto      = (estado == FINAL);
    assign db_tick         = bit_wrap;
    assign db_estado       = {2'b00, estado};
    assign db_saida_serial = saida_serial;

endmodule
